// File: rtl/sop_pkg.sv
// Shared mode encoding for the sum-of-products pipeline.
package sop_pkg;

  typedef logic [1:0] sop_mode_t;

  localparam sop_mode_t SOP_AO  = 2'b00;
  localparam sop_mode_t SOP_AOI = 2'b01;
  localparam sop_mode_t SOP_OA  = 2'b10;
  localparam sop_mode_t SOP_OAI = 2'b11;

  localparam int MODE_OR_FIRST = 1;
  localparam int MODE_INV      = 0;

endpackage

// File: rtl/sop_channel.sv
// One channel of combinational gate logic: group reduction (stage 1) and combine/invert (stage 2).
module sop_channel
  import sop_pkg::*;
#(
  parameter int GRP  = 2,
  parameter int TERM = 3
) (
  input  logic [GRP*TERM-1:0] terms,
  input  logic [1:0]          mode_in,
  output logic [GRP-1:0]      grp,
  input  logic [GRP-1:0]      grp_q,
  input  logic [1:0]          mode_q,
  output logic                y
);

  function automatic logic [GRP-1:0] stage1(input logic [GRP*TERM-1:0] t, input sop_mode_t m);
    logic [GRP-1:0] r;
    r = '0;
    for (int g = 0; g < GRP; g++) begin
      r[g] = m[MODE_OR_FIRST] ? (|t[g*TERM +: TERM]) : (&t[g*TERM +: TERM]);
    end
    return r;
  endfunction

  // Second level uses the dual gate of the first level, then optional inversion.
  function automatic logic stage2(input logic [GRP-1:0] r, input sop_mode_t m);
    logic v;
    v = m[MODE_OR_FIRST] ? (&r) : (|r);
    return v ^ m[MODE_INV];
  endfunction

  assign grp = stage1(terms, mode_in);
  assign y   = stage2(grp_q, mode_q);

endmodule

// File: rtl/sop_logic_pipe.sv
// Two-stage valid/ready sum-of-products pipeline over CH channels of GRP x TERM inputs.
// Optional transfer counter on out_cnt when SOP_XFER_CNT_EN is defined.
module sop_logic_pipe
  import sop_pkg::*;
#(
  parameter int CH   = 2,
  parameter int GRP  = 2,
  parameter int TERM = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_mode,
  input  logic [CH*GRP*TERM-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CH-1:0]          out_data
`ifdef SOP_XFER_CNT_EN
  ,
  output logic [31:0]            out_cnt
`endif
);

  logic              v1;
  sop_mode_t         mode_q;
  logic [CH*GRP-1:0] grp_q;
  logic [CH*GRP-1:0] grp_next;
  logic [CH-1:0]     y_next;
  logic              adv1;
  logic              adv2;

  // Stage 2 advances when it is empty or draining; stage 1 then frees up the same edge.
  assign adv2     = v1 & (~out_valid | out_ready);
  assign in_ready = ~v1 | adv2;
  assign adv1     = in_valid & in_ready;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    sop_channel #(
      .GRP  (GRP),
      .TERM (TERM)
    ) u_ch (
      .terms   (in_data[c*GRP*TERM +: GRP*TERM]),
      .mode_in (in_mode),
      .grp     (grp_next[c*GRP +: GRP]),
      .grp_q   (grp_q[c*GRP +: GRP]),
      .mode_q  (mode_q),
      .y       (y_next[c])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      mode_q    <= SOP_AO;
      grp_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (adv1) begin
        mode_q <= in_mode;
        grp_q  <= grp_next;
      end
      v1 <= adv1 | (v1 & ~adv2);
      if (adv2) begin
        out_data <= y_next;
      end
      out_valid <= adv2 | (out_valid & ~out_ready);
    end
  end

`ifdef SOP_XFER_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt <= '0;
    end else if (out_valid & out_ready) begin
      out_cnt <= out_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sop_logic_pipe.sv
// Randomized and directed bench for sop_logic_pipe against a counting reference model.
module tb_sop_logic_pipe;
  localparam int CH = 2, GRP = 2, TERM = 3, W = CH * GRP * TERM;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [1:0]    in_mode;
  logic [W-1:0]  in_data;
  logic [CH-1:0] out_data;

  logic        p_valid;
  logic [1:0]  p_mode;
  logic [11:0] b_data;
  logic [7:0]  c_data;
  logic        b_in_ready, b_out_valid, c_in_ready, c_out_valid;
  logic [3:0]  b_out;
  logic [0:0]  c_out;
`ifdef SOP_XFER_CNT_EN
  logic [31:0] out_cnt, b_cnt, c_cnt;
`endif

  sop_logic_pipe #(.CH(CH), .GRP(GRP), .TERM(TERM)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef SOP_XFER_CNT_EN
    , .out_cnt(out_cnt)
`endif
  );

  sop_logic_pipe #(.CH(4), .GRP(3), .TERM(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(p_valid), .in_ready(b_in_ready), .in_mode(p_mode),
    .in_data(b_data), .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_out)
`ifdef SOP_XFER_CNT_EN
    , .out_cnt(b_cnt)
`endif
  );

  sop_logic_pipe #(.CH(1), .GRP(1), .TERM(8)) dut_c (
    .clk(clk), .rst(rst), .in_valid(p_valid), .in_ready(c_in_ready), .in_mode(p_mode),
    .in_data(c_data), .out_valid(c_out_valid), .out_ready(1'b1), .out_data(c_out)
`ifdef SOP_XFER_CNT_EN
    , .out_cnt(c_cnt)
`endif
  );

  int n_cmp = 0, n_bad = 0;
  int n_in = 0, n_out = 0;
  int cnt_model = 0;
  logic [CH-1:0] exp_q[$];
  logic          held_vld = 1'b0;
  logic [CH-1:0] held_dat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Channel result from counting ones: AND = all terms set, OR = any term set.
  function automatic logic [CH-1:0] sop_ref(input logic [W-1:0] d, input logic [1:0] m);
    logic [CH-1:0] y;
    int ones, hits;
    logic gv, cv;
    y = '0;
    for (int c = 0; c < CH; c++) begin
      hits = 0;
      for (int g = 0; g < GRP; g++) begin
        ones = 0;
        for (int t = 0; t < TERM; t++) ones += int'(d[c*GRP*TERM + g*TERM + t]);
        gv = m[1] ? (ones > 0) : (ones == TERM);
        hits += int'(gv);
      end
      cv = m[1] ? (hits == GRP) : (hits > 0);
      y[c] = cv ^ m[0];
    end
    return y;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held_vld = 1'b0;
      cnt_model = 0;
    end else begin
      if (held_vld) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(held_dat));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(sop_ref(in_data, in_mode));
        n_in++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
        else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        n_out++;
        cnt_model++;
      end
      held_vld = out_valid && !out_ready;
      held_dat = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && (exp_q.size() != 0 || out_valid); i++) tick();
    tick();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic directed(input logic [W-1:0] d, input logic [1:0] m, input logic [CH-1:0] exp, input string tag);
    in_valid = 1'b1; in_data = d; in_mode = m;
    tick();
    in_valid = 1'b0;
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk(tag, 32'(out_data), 32'(exp));
  endtask

  logic [W-1:0] tx_d[4];
  logic [1:0]   tx_m[4];
  logic         vseq[6];
  logic         rseq[6];
  int idx, base, sent, cyc;
  logic acc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_mode = 2'b00; in_data = '0;
    p_valid = 1'b0; p_mode = 2'b00; b_data = '0; c_data = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Modes with free-flowing output
    out_ready = 1'b1;
    directed(12'b111_000_000_111, 2'b00, 2'b11, "mode_ao");
    directed(12'b111_000_000_111, 2'b01, 2'b00, "mode_aoi");
    directed(12'b001_010_100_000, 2'b10, 2'b10, "mode_oa");
    directed(12'b001_010_100_000, 2'b11, 2'b01, "mode_oai");
    drain();

    // Back-pressure: only two transactions fit while output stalls
    base = n_out;
    for (int i = 0; i < 4; i++) begin tx_d[i] = W'($urandom); tx_m[i] = 2'($urandom); end
    out_ready = 1'b0;
    idx = 0;
    repeat (5) begin
      in_valid = 1'b1; in_data = tx_d[idx]; in_mode = tx_m[idx];
      @(negedge clk); acc = in_ready;
      tick();
      if (acc) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && idx < 4; i++) begin
      in_valid = 1'b1; in_data = tx_d[idx]; in_mode = tx_m[idx];
      @(negedge clk); acc = in_ready;
      tick();
      if (acc) idx++;
    end
    drain();
    chk("bp_out_count", 32'(n_out - base), 32'd4);

    // Bubble between two transactions with pulsed out_ready
    base = n_out;
    vseq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    rseq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      in_valid = vseq[i]; in_data = W'($urandom); in_mode = 2'($urandom); out_ready = rseq[i];
      tick();
    end
    drain();
    chk("bubble_out_count", 32'(n_out - base), 32'd2);

    // Random traffic against the scoreboard
    sent = 0; cyc = 0; acc = 1'b0;
    in_valid = ($urandom % 4) != 0; in_data = W'($urandom); in_mode = 2'($urandom);
    while (sent < 10000 && cyc < 60000) begin
      out_ready = ($urandom % 4) != 0;
      @(negedge clk); acc = in_valid && in_ready;
      if (acc) sent++;
      tick(); cyc++;
      if (!in_valid || acc) begin
        in_valid = ($urandom % 4) != 0; in_data = W'($urandom); in_mode = 2'($urandom);
      end
    end
    chk("rand_sent", 32'(sent), 32'd10000);
    drain();
    chk("rand_in_out", 32'(n_out), 32'(n_in));
`ifdef SOP_XFER_CNT_EN
    chk("xfer_cnt", out_cnt, 32'(cnt_model));
`endif

    // Degenerate geometries
    p_valid = 1'b1; p_mode = 2'b00; b_data = '1; c_data = '1;
    tick();
    p_valid = 1'b0;
    tick();
    chk("b_ao_valid", 32'(b_out_valid), 32'd1);
    chk("b_ao", 32'(b_out), 32'hF);
    chk("c_ao", 32'(c_out), 32'd1);
    p_valid = 1'b1; p_mode = 2'b11;
    tick();
    p_valid = 1'b0;
    tick();
    chk("b_oai_valid", 32'(b_out_valid), 32'd1);
    chk("b_oai", 32'(b_out), 32'h0);
    chk("c_oai", 32'(c_out), 32'd0);

    // Reset with both stages occupied
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = '1; in_mode = 2'b00;
    tick(); tick();
    in_valid = 1'b0;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_data", 32'(out_data), 32'h3);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
`ifdef SOP_XFER_CNT_EN
    chk("midrst_cnt", out_cnt, 32'd0);
`endif
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick(); tick();
    chk("midrst_no_spurious", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
